// File: rtl/tri_vertex_feeder_pkg.sv
// Shared types and constants for the triangle vertex feeder: FSM states,
// coordinate slot indices and default coordinate width.
package tri_vertex_feeder_pkg;

  typedef enum logic [1:0] {
    StCollect = 2'd0,
    StSettle  = 2'd1,
    StEmit    = 2'd2
  } state_e;

  localparam int IDX_W      = 4;
  localparam int CNT_W      = 4;
  localparam int NUM_COORDS = 9;
  localparam int COORD_W    = 16;

  localparam logic [IDX_W-1:0] IDX_AX   = 4'd0;
  localparam logic [IDX_W-1:0] IDX_AY   = 4'd1;
  localparam logic [IDX_W-1:0] IDX_AZ   = 4'd2;
  localparam logic [IDX_W-1:0] IDX_BX   = 4'd3;
  localparam logic [IDX_W-1:0] IDX_BY   = 4'd4;
  localparam logic [IDX_W-1:0] IDX_BZ   = 4'd5;
  localparam logic [IDX_W-1:0] IDX_CX   = 4'd6;
  localparam logic [IDX_W-1:0] IDX_CY   = 4'd7;
  localparam logic [IDX_W-1:0] IDX_CZ   = 4'd8;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_CZ;

endpackage

// File: rtl/tri_vertex_feeder.sv
// Collects nine coordinate words into vertex registers, waits for the external
// shade datapath to settle, then presents the captured intensity with a tag.
module tri_vertex_feeder
  import tri_vertex_feeder_pkg::*;
#(
  parameter int WII        = 8,
  parameter int WIF        = 8,
  parameter int SETTLE_CYC = 2,
  parameter int ID_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WII+WIF-1:0]   s_data,
  input  logic                 s_last,
  output logic [WII+WIF-1:0]   vax,
  output logic [WII+WIF-1:0]   vay,
  output logic [WII+WIF-1:0]   vaz,
  output logic [WII+WIF-1:0]   vbx,
  output logic [WII+WIF-1:0]   vby,
  output logic [WII+WIF-1:0]   vbz,
  output logic [WII+WIF-1:0]   vcx,
  output logic [WII+WIF-1:0]   vcy,
  output logic [WII+WIF-1:0]   vcz,
  input  logic [5:0]           shade_in,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [5:0]           m_shade,
  output logic [ID_W-1:0]      m_id,
  output logic                 frame_err
);

  localparam int W = WII + WIF;
  localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYC - 1);

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     vtx [NUM_COORDS];
  logic             fire;
  logic             framing_bad;

  assign fire        = s_valid && s_ready;
  assign framing_bad = s_last != (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StCollect;
      idx       <= '0;
      cnt       <= '0;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      m_shade   <= '0;
      m_id      <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_COORDS; i++) vtx[i] <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        StCollect: begin
          s_ready <= 1'b1;
          if (fire) begin
            if (framing_bad) begin
              // Discard the offending word and restart the triangle at ax.
              idx       <= '0;
              frame_err <= 1'b1;
            end else begin
              vtx[idx] <= s_data;
              if (s_last) begin
                state   <= StSettle;
                idx     <= '0;
                cnt     <= SettleLoad;
                s_ready <= 1'b0;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
        end
        StSettle: begin
          if (cnt == '0) begin
            m_shade <= shade_in;
            state   <= StEmit;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StEmit: begin
          // m_valid rises one edge after capture; m_ready is ignored until then.
          if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_id    <= m_id + 1'b1;
            state   <= StCollect;
            s_ready <= 1'b1;
          end else begin
            m_valid <= 1'b1;
          end
        end
        default: begin
          state   <= StCollect;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

  assign vax = vtx[IDX_AX];
  assign vay = vtx[IDX_AY];
  assign vaz = vtx[IDX_AZ];
  assign vbx = vtx[IDX_BX];
  assign vby = vtx[IDX_BY];
  assign vbz = vtx[IDX_BZ];
  assign vcx = vtx[IDX_CX];
  assign vcy = vtx[IDX_CY];
  assign vcz = vtx[IDX_CZ];

endmodule

// File: tb/tb_tri_vertex_feeder.sv
// Self-checking bench: table of directed triangles, reset-abort sequence, then
// randomized triangles checked against a word-list model of the vertex store.
module tb_tri_vertex_feeder;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, s_last;
  logic [15:0] s_data;
  logic [15:0] vax, vay, vaz, vbx, vby, vbz, vcx, vcy, vcz;
  logic [5:0]  shade_in, m_shade;
  logic        m_valid, m_ready, frame_err;
  logic [7:0]  m_id;

  tri_vertex_feeder #(.WII(8), .WIF(8), .SETTLE_CYC(SETTLE), .ID_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .vax(vax), .vay(vay), .vaz(vaz), .vbx(vbx), .vby(vby), .vbz(vbz),
    .vcx(vcx), .vcy(vcy), .vcz(vcz), .shade_in(shade_in), .m_valid(m_valid),
    .m_ready(m_ready), .m_shade(m_shade), .m_id(m_id), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int last_acc;
  logic [15:0] mv [9];   // model of vertex store
  int exp_id = 0;        // model of triangle tag (count of consumed results)
  logic [15:0] vout [9];

  always_comb begin
    vout[0] = vax; vout[1] = vay; vout[2] = vaz;
    vout[3] = vbx; vout[4] = vby; vout[5] = vbz;
    vout[6] = vcx; vout[7] = vcy; vout[8] = vcz;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_vtx(input string name);
    for (int i = 0; i < 9; i++) chk($sformatf("%s v%0d", name, i), vout[i], mv[i]);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input logic [15:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("s_ready timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    last_acc = cyc;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // lp: index carrying s_last (8 = well-formed, <8 early, -1 never).
  task automatic run_tri(input logic [8:0][15:0] w, input int lp, input logic [5:0] sh,
                         input int hold, input logic [5:0] alt, input bit exp_err,
                         input logic [5:0] exp_sh);
    int nw;
    int n;
    nw = (lp < 0) ? 9 : lp + 1;
    shade_in = sh;
    for (int i = 0; i < nw; i++) begin
      send_word(w[i], 1'(i == lp));
      if (!(exp_err && i == nw - 1)) mv[i] = w[i];
    end
    if (exp_err) begin
      chk("frame_err pulse", frame_err, 1);
      @(negedge clk);
      chk("frame_err drop", frame_err, 0);
      repeat (4) @(negedge clk);
      chk("no m_valid after err", m_valid, 0);
      chk("s_ready after err", s_ready, 1);
      chk("m_id after err", m_id, exp_id);
      chk_vtx("err vtx");
      return;
    end
    chk("no frame_err", frame_err, 0);
    chk("s_ready settle", s_ready, 0);
    chk_vtx("vtx");
    n = 0;
    while (!m_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", cyc - last_acc, SETTLE + 1);
    shade_in = alt;
    for (int k = 0; k < hold; k++) begin
      chk("hold m_valid", m_valid, 1);
      chk("hold s_ready", s_ready, 0);
      chk("hold m_shade", m_shade, exp_sh);
      @(negedge clk);
    end
    chk("m_shade", m_shade, exp_sh);
    chk("m_id", m_id, exp_id);
    chk_vtx("emit vtx");
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    exp_id = (exp_id + 1) % 256;
    chk("m_valid drop", m_valid, 0);
    chk("s_ready back", s_ready, 1);
    chk("m_id inc", m_id, exp_id);
  endtask

  typedef struct {
    logic [8:0][15:0] w;
    int               lp;
    logic [5:0]       sh;
    int               hold;
    logic [5:0]       alt;
    bit               exp_err;
    logic [5:0]       exp_sh;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [8:0][15:0] rw;
    int lp;
    bit err;
    logic [5:0] sh;

    tbl[0] = '{w: {16'h0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0},
               lp: 8, sh: 6'd24, hold: 5, alt: 6'd8, exp_err: 1'b0, exp_sh: 6'd24};
    tbl[1] = '{w: {16'h9, 16'h8, 16'h7, 16'h6, 16'h5, 16'h4, 16'h3, 16'h2, 16'h1},
               lp: 3, sh: 6'd5, hold: 0, alt: 6'd5, exp_err: 1'b1, exp_sh: 6'd0};
    tbl[2] = '{w: {16'h0A09, 16'h0A08, 16'h0A07, 16'h0A06, 16'h0A05, 16'h0A04, 16'h0A03,
                   16'h0A02, 16'h0A01},
               lp: 8, sh: 6'd33, hold: 0, alt: 6'd1, exp_err: 1'b0, exp_sh: 6'd33};
    tbl[3] = '{w: {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777,
                   16'h8888, 16'h9999},
               lp: -1, sh: 6'd12, hold: 0, alt: 6'd12, exp_err: 1'b1, exp_sh: 6'd0};
    tbl[4] = '{w: {16'h8000, 16'h7FFF, 16'hFF00, 16'h0080, 16'hFFFF, 16'h0001, 16'hC000,
                   16'h4000, 16'hFF80},
               lp: 8, sh: 6'd63, hold: 2, alt: 6'd0, exp_err: 1'b0, exp_sh: 6'd63};

    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    shade_in = '0;
    for (int i = 0; i < 9; i++) mv[i] = '0;

    // Reset state, and m_ready while idle must be ignored.
    repeat (3) @(negedge clk);
    chk("rst s_ready", s_ready, 0);
    chk("rst m_valid", m_valid, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst m_id", m_id, 0);
    chk("rst m_shade", m_shade, 0);
    chk_vtx("rst");
    rst_n = 1'b1;
    m_ready = 1'b1;
    #1 chk("s_ready before edge", s_ready, 0);
    @(negedge clk);
    chk("s_ready after edge", s_ready, 1);
    @(negedge clk);
    m_ready = 1'b0;
    chk("idle m_ready ignored", m_id, 0);

    for (int t = 0; t < 5; t++)
      run_tri(tbl[t].w, tbl[t].lp, tbl[t].sh, tbl[t].hold, tbl[t].alt, tbl[t].exp_err,
              tbl[t].exp_sh);

    // Reset after word 5 aborts the triangle and clears everything.
    for (int i = 0; i < 5; i++) send_word(16'h0F00 + 16'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 9; i++) mv[i] = '0;
    exp_id = 0;
    chk("abort m_id", m_id, 0);
    chk("abort s_ready", s_ready, 0);
    chk("abort m_valid", m_valid, 0);
    chk_vtx("abort");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("abort s_ready low", s_ready, 0);
    @(negedge clk);
    chk("abort s_ready high", s_ready, 1);
    run_tri(tbl[2].w, 8, 6'd17, 1, 6'd2, 1'b0, 6'd17);

    // Randomized: first 257 clean triangles exercise the tag wrap, then errors mix in.
    exp_id = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) mv[i] = '0;
    @(negedge clk);
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < 9; i++) rw[i] = 16'($urandom);
      sh = 6'($urandom);
      lp = 8;
      if (t >= 257 && $urandom_range(0, 3) == 0) begin
        lp = $urandom_range(0, 8);
        if (lp == 8) lp = -1;
      end
      err = (lp != 8);
      if (t == 256) chk("257th m_id", m_id, 0);
      run_tri(rw, lp, sh, $urandom_range(0, 3), 6'($urandom), err, sh);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule
